// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the SEQ datapath and its sequencer.
//   - Architectural status codes (stat register values).
//   - Instruction codes (icode field of the first instruction byte).
//   - seq_state_t: sequencer states, one per datapath stage plus IDLE/HALTED.
package y86_pkg;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_PCUPD  = 3'd6,
    ST_HALTED = 3'd7
  } seq_state_t;

endpackage

// File: rtl/seq_perf_counters.sv
// Retired-instruction and busy-cycle counters for the SEQ sequencer.
// Ports:
//   clk, rst     clock, asynchronous active-high reset (clears both counters)
//   retire       one-cycle pulse per retired instruction
//   busy         high while the sequencer is stepping an instruction
//   instr_count  retired instructions, wraps modulo 2^CNT_W
//   cycle_count  busy cycles, wraps modulo 2^CNT_W
module seq_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire,
  input  logic             busy,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
      cycle_count <= '0;
    end else begin
      if (retire) instr_count <= instr_count + CNT_W'(1);
      if (busy)   cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle sequencer for the SEQ Y86-64 datapath. Owns the architectural
// PC and stat registers and walks the datapath one stage per clock:
// FETCH, DECODE, EXEC, MEM, WB, PCUPD (6 cycles per instruction).
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   run                     level: keep executing while high
//   step                    pulse: execute one instruction from IDLE
//   icode, instr_valid,
//   imem_error              fetch results, checked in DECODE
//   dmem_error              data memory fault, checked in MEM
//   updated_pc              next PC from pc_update, loaded in PCUPD
//   PC                      architectural PC
//   fetch_en..pc_en         one-hot stage strobes (decode of state)
//   stat                    AOK/HLT/ADR/INS
//   busy, halted            sequencer activity / terminal halt
//   instr_count,
//   cycle_count             performance counters
//   state                   current FSM state, for observation
// Handshake: run/step are sampled only in IDLE; a step pulse arriving
// while busy is dropped. run is re-sampled at PCUPD to decide whether to
// continue into the next FETCH (only if the sequence was started by run).
module seq_controller
  import y86_pkg::*;
#(
  parameter logic [63:0] PC_RESET  = 64'd32,
  parameter logic [31:0] MAX_INSTR = 32'd0,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             dmem_error,
  input  logic [63:0]      updated_pc,
  output logic [63:0]      PC,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic             pc_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output seq_state_t       state
);

  seq_state_t next_state;
  logic [2:0] next_stat;
  logic       retire;
  logic       run_mode;
  logic       start;
  logic       limit_hit;

  assign start = (state == ST_IDLE) && (run || step);

  // Count after this retirement equals the limit (limit 0 disables).
  assign limit_hit = (MAX_INSTR != 32'd0) &&
                     ((instr_count + CNT_W'(1)) == CNT_W'(MAX_INSTR));

  always_comb begin
    next_state = state;
    next_stat  = stat;
    retire     = 1'b0;
    case (state)
      ST_IDLE:   if (run || step) next_state = ST_FETCH;
      ST_FETCH:  next_state = ST_DECODE;
      ST_DECODE: begin
        // Priority: address fault, then illegal instruction, then halt.
        if (imem_error) begin
          next_stat  = STAT_ADR;
          next_state = ST_HALTED;
        end else if (!instr_valid) begin
          next_stat  = STAT_INS;
          next_state = ST_HALTED;
        end else if (icode == I_HALT) begin
          next_stat  = STAT_HLT;
          retire     = 1'b1;
          next_state = ST_HALTED;
        end else begin
          next_state = ST_EXEC;
        end
      end
      ST_EXEC:   next_state = ST_MEM;
      ST_MEM: begin
        if (dmem_error) begin
          next_stat  = STAT_ADR;
          next_state = ST_HALTED;
        end else begin
          next_state = ST_WB;
        end
      end
      ST_WB:     next_state = ST_PCUPD;
      ST_PCUPD: begin
        retire = 1'b1;
        if (limit_hit)             next_state = ST_IDLE;
        else if (run_mode && run)  next_state = ST_FETCH;
        else                       next_state = ST_IDLE;
      end
      ST_HALTED: next_state = ST_HALTED;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      stat     <= STAT_AOK;
      PC       <= PC_RESET;
      run_mode <= 1'b0;
    end else begin
      state <= next_state;
      stat  <= next_stat;
      if (start)             run_mode <= run;
      if (state == ST_PCUPD) PC <= updated_pc;
    end
  end

  assign fetch_en  = (state == ST_FETCH);
  assign decode_en = (state == ST_DECODE);
  assign exec_en   = (state == ST_EXEC);
  assign mem_en    = (state == ST_MEM);
  assign wb_en     = (state == ST_WB);
  assign pc_en     = (state == ST_PCUPD);
  assign busy      = (state != ST_IDLE) && (state != ST_HALTED);
  assign halted    = (state == ST_HALTED);

  seq_perf_counters #(.CNT_W(CNT_W)) u_counters (
    .clk         (clk),
    .rst         (rst),
    .retire      (retire),
    .busy        (busy),
    .instr_count (instr_count),
    .cycle_count (cycle_count)
  );

endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: a default instance (unlimited) and a
// second instance with a retire limit of 2.
module tb_seq_controller;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [3:0]  cur_icode = 4'h3;
  logic        instr_valid = 1'b1;
  logic        imem_error = 1'b0;
  logic        dmem_error = 1'b0;
  logic [63:0] halt_pc = '1;
  logic [63:0] pc_inc = 64'd10;
  logic [3:0]  icode;
  logic [63:0] updated_pc;

  logic [63:0] pc;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
  logic [2:0]  stat;
  logic        busy, halted;
  logic [31:0] instr_count, cycle_count;
  seq_state_t  state;
  logic [5:0]  strb;

  logic        run2 = 1'b0;
  logic        step2 = 1'b0;
  logic [63:0] pc2, updated_pc2;
  logic        f2, d2, e2, m2, w2, p2;
  logic [2:0]  stat2;
  logic        busy2, halted2;
  logic [31:0] instr_count2, cycle_count2;
  seq_state_t  state2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Tiny program model: halt at halt_pc, otherwise cur_icode; sequential PCs.
  assign icode       = (pc == halt_pc) ? I_HALT : cur_icode;
  assign updated_pc  = pc + pc_inc;
  assign updated_pc2 = pc2 + 64'd10;
  assign strb        = {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en};

  seq_controller dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .icode(icode),
    .instr_valid(instr_valid), .imem_error(imem_error), .dmem_error(dmem_error),
    .updated_pc(updated_pc), .PC(pc), .fetch_en(fetch_en), .decode_en(decode_en),
    .exec_en(exec_en), .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en), .stat(stat),
    .busy(busy), .halted(halted), .instr_count(instr_count),
    .cycle_count(cycle_count), .state(state)
  );

  seq_controller #(.MAX_INSTR(32'd2)) dut_lim (
    .clk(clk), .rst(rst), .run(run2), .step(step2), .icode(I_IRMOVQ),
    .instr_valid(1'b1), .imem_error(1'b0), .dmem_error(1'b0),
    .updated_pc(updated_pc2), .PC(pc2), .fetch_en(f2), .decode_en(d2),
    .exec_en(e2), .mem_en(m2), .wb_en(w2), .pc_en(p2), .stat(stat2),
    .busy(busy2), .halted(halted2), .instr_count(instr_count2),
    .cycle_count(cycle_count2), .state(state2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_defaults();
    run = 0; step = 0; cur_icode = I_IRMOVQ; instr_valid = 1; imem_error = 0;
    dmem_error = 0; halt_pc = '1; pc_inc = 64'd10; run2 = 0; step2 = 0;
  endtask

  task automatic test_reset();
    set_defaults();
    do_reset();
    n_total++;
    if (state !== ST_IDLE || pc !== 64'd32 || stat !== 3'd1 || strb !== 6'b0 ||
        busy !== 1'b0 || halted !== 1'b0 || instr_count !== 0 || cycle_count !== 0)
      $display("FAIL reset_init: state=%0d pc=%0d stat=%0d strb=%b busy=%b halted=%b ic=%0d cc=%0d required 0/32/1/000000/0/0/0/0",
               state, pc, stat, strb, busy, halted, instr_count, cycle_count);
    else n_pass++;
    // One instruction moves PC to 0x40, then stop the next one in EXEC.
    pc_inc = 64'd32;
    step = 1; tick(); step = 0;
    repeat (6) tick();
    step = 1; tick(); step = 0;
    tick(); tick();
    n_total++;
    if (state !== ST_EXEC || pc !== 64'h40)
      $display("FAIL reset_pre: state=%0d pc=%h required 3/40", state, pc);
    else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_total++;
    if (state !== ST_IDLE || pc !== 64'd32 || stat !== 3'd1 || strb !== 6'b0 ||
        instr_count !== 0 || cycle_count !== 0)
      $display("FAIL reset_async: state=%0d pc=%0d stat=%0d strb=%b ic=%0d cc=%0d required 0/32/1/000000/0/0",
               state, pc, stat, strb, instr_count, cycle_count);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_total++;
    if (state !== ST_IDLE || pc !== 64'd32 || busy !== 1'b0 || strb !== 6'b0)
      $display("FAIL reset_after: state=%0d pc=%0d busy=%b strb=%b required 0/32/0/000000",
               state, pc, busy, strb);
    else n_pass++;
  endtask

  task automatic test_step();
    set_defaults();
    do_reset();
    step = 1; tick(); step = 0;
    for (int c = 1; c <= 6; c++) begin
      n_total++;
      if (strb !== (6'b100000 >> (c - 1)) || busy !== 1'b1)
        $display("FAIL step_strobe_c%0d: strb=%b busy=%b required %b/1", c, strb, busy,
                 6'b100000 >> (c - 1));
      else n_pass++;
      if (c < 6) tick();
    end
    tick();
    n_total++;
    if (state !== ST_IDLE || pc !== 64'd42 || instr_count !== 1 || cycle_count !== 6 ||
        stat !== 3'd1 || strb !== 6'b0)
      $display("FAIL step_done: state=%0d pc=%0d ic=%0d cc=%0d stat=%0d strb=%b required 0/42/1/6/1/000000",
               state, pc, instr_count, cycle_count, stat, strb);
    else n_pass++;
  endtask

  task automatic test_run_halt();
    int cycles;
    set_defaults();
    do_reset();
    halt_pc = 64'd62;
    run = 1;
    cycles = 0;
    while (!halted && cycles < 40) begin
      tick();
      cycles++;
    end
    n_total++;
    if (cycles !== 21)
      $display("FAIL run_halt_latency: ticks=%0d required 21", cycles);
    else n_pass++;
    n_total++;
    if (instr_count !== 4 || stat !== 3'd2 || halted !== 1'b1 || pc !== 64'd62 ||
        cycle_count !== 20 || busy !== 1'b0)
      $display("FAIL run_halt_state: ic=%0d stat=%0d halted=%b pc=%0d cc=%0d busy=%b required 4/2/1/62/20/0",
               instr_count, stat, halted, pc, cycle_count, busy);
    else n_pass++;
    step = 1;
    repeat (3) tick();
    step = 0; run = 0;
    n_total++;
    if (halted !== 1'b1 || stat !== 3'd2 || pc !== 64'd62 || cycle_count !== 20 ||
        strb !== 6'b0)
      $display("FAIL halted_sticky: halted=%b stat=%0d pc=%0d cc=%0d strb=%b required 1/2/62/20/000000",
               halted, stat, pc, cycle_count, strb);
    else n_pass++;
  endtask

  task automatic test_fault(input bit use_dmem);
    bit bad;
    int cycles;
    set_defaults();
    do_reset();
    if (use_dmem) begin
      cur_icode = I_MRMOVQ;
      dmem_error = 1;
    end else begin
      instr_valid = 0;
    end
    step = 1; tick(); step = 0;
    bad = 0;
    cycles = 0;
    while (!halted && cycles < 10) begin
      if (wb_en || pc_en || (!use_dmem && exec_en)) bad = 1;
      tick();
      cycles++;
    end
    n_total++;
    if (use_dmem) begin
      if (stat !== 3'd3 || halted !== 1'b1 || bad !== 1'b0 || pc !== 64'd32 ||
          instr_count !== 0 || cycle_count !== 4)
        $display("FAIL dmem_fault: stat=%0d halted=%b bad_strobe=%b pc=%0d ic=%0d cc=%0d required 3/1/0/32/0/4",
                 stat, halted, bad, pc, instr_count, cycle_count);
      else n_pass++;
    end else begin
      if (stat !== 3'd4 || halted !== 1'b1 || bad !== 1'b0 || pc !== 64'd32 ||
          instr_count !== 0 || cycle_count !== 2)
        $display("FAIL invalid_instr: stat=%0d halted=%b bad_strobe=%b pc=%0d ic=%0d cc=%0d required 4/1/0/32/0/2",
                 stat, halted, bad, pc, instr_count, cycle_count);
      else n_pass++;
    end
  endtask

  task automatic test_imem_priority();
    set_defaults();
    do_reset();
    imem_error = 1; instr_valid = 0; halt_pc = 64'd32;
    step = 1; tick(); step = 0;
    tick(); tick();
    n_total++;
    if (stat !== 3'd3 || halted !== 1'b1 || instr_count !== 0)
      $display("FAIL imem_priority: stat=%0d halted=%b ic=%0d required 3/1/0",
               stat, halted, instr_count);
    else n_pass++;
  endtask

  task automatic test_run_drop();
    set_defaults();
    do_reset();
    run = 1; tick(); run = 0;
    step = 1; tick(); step = 0;
    repeat (5) tick();
    n_total++;
    if (state !== ST_IDLE || instr_count !== 1 || pc !== 64'd42)
      $display("FAIL run_drop: state=%0d ic=%0d pc=%0d required 0/1/42",
               state, instr_count, pc);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (state !== ST_IDLE || instr_count !== 1 || cycle_count !== 6)
      $display("FAIL step_ignored: state=%0d ic=%0d cc=%0d required 0/1/6",
               state, instr_count, cycle_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back_limit();
    int cycles;
    set_defaults();
    do_reset();
    run2 = 1; step2 = 1; tick(); step2 = 0;
    cycles = 1;
    while (state2 !== ST_IDLE && cycles < 30) begin
      tick();
      cycles++;
    end
    run2 = 0;
    n_total++;
    if (cycles !== 13 || cycle_count2 !== 12 || stat2 !== 3'd1 || instr_count2 !== 2 ||
        pc2 !== 64'd52 || halted2 !== 1'b0)
      $display("FAIL max_instr: ticks=%0d cc=%0d stat=%0d ic=%0d pc=%0d halted=%b required 13/12/1/2/52/0",
               cycles, cycle_count2, stat2, instr_count2, pc2, halted2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_halt();
    test_fault(1'b0);
    test_fault(1'b1);
    test_imem_priority();
    test_run_drop();
    test_back_to_back_limit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
Name: seq_controller

Overview:
- Multi-cycle sequencer for the single-cycle-per-stage SEQ Y86-64 datapath (fetch, decode/regfile, execute, memory, pc_update).
- Owns the architectural PC and status registers and steps the datapath through one stage per clock.
- Detects halt, invalid-instruction and address faults, supports run and single-step modes, and keeps retired-instruction and cycle counters for the testbench.
- Replaces the free-running PC loop and combinational stat/$finish logic in the top level.

Parameters:
- PC_RESET, 64'd32, PC value loaded on reset.
- MAX_INSTR, 32'd0, retire limit; 0 = unlimited.
- CNT_W, 32, width of instr_count and cycle_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; continuous execution while high.
- step  in  1  one-cycle pulse; execute exactly one instruction from IDLE.
- icode  in  4  from fetch; valid from DECODE state onward.
- instr_valid  in  1  from fetch; 1 = legal instruction.
- imem_error  in  1  from fetch; instruction address out of range.
- dmem_error  in  1  from memory; data address out of range, valid in MEM state.
- updated_pc  in  64  next PC from pc_update.
- PC  out  64  architectural PC driven to fetch and pc_update.
- fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en  out  1 each  stage strobes, one-hot, high for exactly one cycle.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  out  1  high in any state except IDLE and HALTED.
- halted  out  1  high in HALTED.
- instr_count  out  CNT_W  retired instructions.
- cycle_count  out  CNT_W  cycles spent outside IDLE and HALTED.

Behaviour:
- Reset (async, any state): state=IDLE, PC=PC_RESET, stat=AOK, all strobes 0, busy=0, halted=0, both counters 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALTED. Strobe outputs are a decode of the state (FETCH→fetch_en, ..., PCUPD→pc_en).
- IDLE→FETCH when run=1 or step=1. If both are high, run wins. Record run_mode=run.
- FETCH→DECODE unconditionally.
- DECODE: fault check, first match wins:
  - imem_error → stat=ADR, go to HALTED.
  - !instr_valid → stat=INS, go to HALTED.
  - icode==4'h0 (halt) → stat=HLT, instr_count+1, go to HALTED.
  - Otherwise → EXEC.
- EXEC→MEM unconditionally.
- MEM: dmem_error=1 → stat=ADR, go to HALTED. wb_en and pc_en are never asserted for that instruction. Otherwise → WB.
- WB→PCUPD unconditionally.
- PCUPD:
  - PC<=updated_pc and instr_count+1 on the same edge.
  - If MAX_INSTR!=0 and the new count equals MAX_INSTR → IDLE with stat kept at AOK.
  - Else if run_mode and run still high → FETCH.
  - Else → IDLE.
- Latency: 6 cycles per instruction. First fetch_en is the cycle after run/step is sampled.
- run deasserted mid-instruction: the current instruction completes through PCUPD, then IDLE. No abort.
- step pulses received while busy are ignored.
- HALTED is terminal. Only rst exits it. PC holds the address of the halting or faulting instruction. stat is frozen.
- cycle_count increments every cycle while busy. Both counters wrap modulo 2^CNT_W.
- No datapath state changes without a strobe. The team's datapath modules gate their register and memory writes with wb_en and mem_en.

Decomposition:
- Shared package y86_pkg holds:
  - stat codes STAT_AOK=3'd1, STAT_HLT=3'd2, STAT_ADR=3'd3, STAT_INS=3'd4;
  - icode constants (I_HALT=4'h0 ... I_POPQ=4'hB);
  - the seq_state_t enum.
- One sub-module is natural: seq_perf_counters (instr_count and cycle_count with wrap). The FSM and PC/stat registers stay in seq_controller.

Test Plan:
- Reset mid-EXEC with PC=0x40 → next cycle state=IDLE, PC=32, stat=1, counters 0, no strobes.
- step pulse, instruction irmovq (icode=3, valid), updated_pc=42 → strobes fire FETCH..PCUPD on cycles 1-6, PC=42 after cycle 6, instr_count=1, cycle_count=6, state IDLE.
- run held high, 3 valid instructions then icode=0 → instr_count=4, stat=2, halted=1, PC=address of halt, cycle_count=20 (3×6 + FETCH + DECODE).
- instr_valid=0 at DECODE → stat=4, HALTED, no exec_en/wb_en/pc_en, instr_count unchanged.
- dmem_error=1 in MEM on a mrmovq → stat=3, wb_en and pc_en never asserted, PC unchanged.
- MAX_INSTR=2, run held → IDLE after 12 cycles, stat=1, instr_count=2; run and step both high in IDLE → continuous mode taken.
